// File: rtl/count_pkg.sv
// Shared definitions for the count sequence checker: code width, FSM state
// encoding and the mode encodings of the incoming count code.
package count_pkg;

  localparam int unsigned CodeW = 3;

  typedef enum logic [1:0] {
    StHunt  = 2'b00,
    StTrack = 2'b01,
    StLock  = 2'b10
  } state_e;

  typedef enum logic {
    ModeBin  = 1'b0,
    ModeGray = 1'b1
  } mode_e;

  // Successor of a binary count value; the wrap from all-ones to zero is legal.
  function automatic logic [CodeW-1:0] next_count(input logic [CodeW-1:0] v);
    return v + {{(CodeW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/gray_dec3.sv
// 3-bit reflected Gray to binary converter, purely combinational.
module gray_dec3 (
  input  logic [2:0] gray,
  output logic [2:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin[2] = gray[2];
    bin[1] = gray[2] ^ gray[1];
    bin[0] = gray[2] ^ gray[1] ^ gray[0];
  end

endmodule

// File: rtl/count_seq_checker.sv
// Watches a 3-bit binary or Gray counter, locks after LOCK_COUNT correct
// successors and flags breaks in the sequence while locked.
module count_seq_checker
  import count_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned ERR_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             mode,
  input  logic [CodeW-1:0] code,
  output logic [CodeW-1:0] bin,
  output logic             locked,
  output logic             seq_err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count
);

  // Good-successor counter wide enough for LOCK_COUNT up to 15.
  localparam int unsigned GoodW = 4;
  localparam logic [GoodW-1:0] LockTarget = GoodW'(LOCK_COUNT);

  state_e             state_q, state_d;
  logic [GoodW-1:0]   good_cnt_q, good_cnt_d;
  logic               mode_q, mode_d;
  logic [CodeW-1:0]   bin_q, bin_d;
  logic               locked_q, locked_d;
  logic               seq_err_q, seq_err_d;
  logic               wrap_q, wrap_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic [CodeW-1:0]   gray_bin;
  logic [CodeW-1:0]   dec;
  logic [CodeW-1:0]   exp_val;
  logic [GoodW-1:0]   good_inc;

  gray_dec3 u_gray_dec3 (
    .gray (code),
    .bin  (gray_bin)
  );

  // Decode the sample into binary and form the expected successor of the reference.
  always_comb begin
    dec      = (mode_e'(mode) == ModeGray) ? gray_bin : code;
    exp_val  = next_count(bin_q);
    good_inc = good_cnt_q + {{(GoodW-1){1'b0}}, 1'b1};
  end

  // Next-state and registered-output logic for the lock FSM.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    mode_d     = mode_q;
    bin_d      = bin_q;
    seq_err_d  = 1'b0;
    wrap_d     = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (valid) begin
      // The last accepted sample always becomes the new reference.
      bin_d  = dec;
      mode_d = mode;

      case (state_q)
        StTrack, StLock: begin
          if (mode != mode_q) begin
            // Switching encodings is a resync, never an error.
            state_d    = StTrack;
            good_cnt_d = '0;
          end else if (dec == exp_val) begin
            wrap_d = (dec == '0);
            if (state_q == StTrack) begin
              if (good_inc == LockTarget) begin
                state_d    = StLock;
                good_cnt_d = '0;
              end else begin
                good_cnt_d = good_inc;
              end
            end
          end else begin
            state_d    = StTrack;
            good_cnt_d = '0;
            if (state_q == StLock) begin
              seq_err_d = 1'b1;
              if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
              end
            end
          end
        end
        default: begin
          // HUNT (or an illegal encoding): take the sample as the first reference.
          state_d    = StTrack;
          good_cnt_d = '0;
        end
      endcase
    end

    locked_d = (state_d == StLock);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StHunt;
      good_cnt_q <= '0;
      mode_q     <= 1'b0;
      bin_q      <= '0;
      locked_q   <= 1'b0;
      seq_err_q  <= 1'b0;
      wrap_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      mode_q     <= mode_d;
      bin_q      <= bin_d;
      locked_q   <= locked_d;
      seq_err_q  <= seq_err_d;
      wrap_q     <= wrap_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bin       = bin_q;
  assign locked    = locked_q;
  assign seq_err   = seq_err_q;
  assign wrap      = wrap_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: one default instance for the main
// scenarios and one ERR_W=2 instance for error-counter saturation.
module tb_count_seq_checker;

  logic       clk;
  logic       reset;
  logic       valid, mode;
  logic [2:0] code;
  logic [2:0] bin;
  logic       locked, seq_err, wrap;
  logic [3:0] err_count;

  logic       valid2, mode2;
  logic [2:0] code2;
  logic [2:0] bin2;
  logic       locked2, seq_err2, wrap2;
  logic [1:0] err_count2;

  int unsigned n_vec;
  int unsigned n_bad;

  count_seq_checker #(
    .LOCK_COUNT (3),
    .ERR_W      (4)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .mode      (mode),
    .code      (code),
    .bin       (bin),
    .locked    (locked),
    .seq_err   (seq_err),
    .wrap      (wrap),
    .err_count (err_count)
  );

  count_seq_checker #(
    .LOCK_COUNT (3),
    .ERR_W      (2)
  ) u_dut_sat (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid2),
    .mode      (mode2),
    .code      (code2),
    .bin       (bin2),
    .locked    (locked2),
    .seq_err   (seq_err2),
    .wrap      (wrap2),
    .err_count (err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic expect_main(input string tag, input int unsigned b, input int unsigned l,
                             input int unsigned se, input int unsigned w,
                             input int unsigned e);
    check({tag, ".bin"}, 32'(bin), b);
    check({tag, ".locked"}, 32'(locked), l);
    check({tag, ".seq_err"}, 32'(seq_err), se);
    check({tag, ".wrap"}, 32'(wrap), w);
    check({tag, ".err_count"}, 32'(err_count), e);
  endtask

  // Drive one sample on the main instance and move to just after the edge.
  task automatic step(input logic v, input logic m, input logic [2:0] c);
    valid = v;
    mode  = m;
    code  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic v, input logic [2:0] c);
    valid2 = v;
    mode2  = 1'b0;
    code2  = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    reset  = 1'b0;
    valid  = 1'b0;
    mode   = 1'b0;
    code   = 3'd0;
    valid2 = 1'b0;
    mode2  = 1'b0;
    code2  = 3'd0;

    @(posedge clk);
    @(posedge clk);
    #1;
    expect_main("reset", 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Binary lock on 0,1,2,3.
    step(1'b1, 1'b0, 3'd0); expect_main("bin0", 0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 3'd1); expect_main("bin1", 1, 0, 0, 0, 0);
    step(1'b1, 1'b0, 3'd2); expect_main("bin2", 2, 0, 0, 0, 0);
    step(1'b1, 1'b0, 3'd3); expect_main("bin3", 3, 1, 0, 0, 0);
    step(1'b1, 1'b0, 3'd4); expect_main("bin4", 4, 1, 0, 0, 0);
    step(1'b1, 1'b0, 3'd5); expect_main("bin5", 5, 1, 0, 0, 0);
    step(1'b1, 1'b0, 3'd6); expect_main("bin6", 6, 1, 0, 0, 0);

    // Break while locked, then relock.
    step(1'b1, 1'b0, 3'd1); expect_main("brk", 1, 0, 1, 0, 1);
    step(1'b1, 1'b0, 3'd2); expect_main("re2", 2, 0, 0, 0, 1);
    step(1'b1, 1'b0, 3'd3); expect_main("re3", 3, 0, 0, 0, 1);
    step(1'b1, 1'b0, 3'd4); expect_main("re4", 4, 1, 0, 0, 1);
    step(1'b1, 1'b0, 3'd5); expect_main("re5", 5, 1, 0, 0, 1);

    // Mode change to Gray is a silent resync; then relock in Gray.
    step(1'b1, 1'b1, 3'b011); expect_main("mchg", 2, 0, 0, 0, 1);
    step(1'b1, 1'b1, 3'b010); expect_main("g3", 3, 0, 0, 0, 1);
    step(1'b1, 1'b1, 3'b110); expect_main("g4", 4, 0, 0, 0, 1);
    step(1'b1, 1'b1, 3'b111); expect_main("g5", 5, 1, 0, 0, 1);

    // Gray wrap 7 -> 0 pulses wrap exactly once.
    step(1'b1, 1'b1, 3'b101); expect_main("g6", 6, 1, 0, 0, 1);
    step(1'b1, 1'b1, 3'b100); expect_main("g7", 7, 1, 0, 0, 1);
    step(1'b1, 1'b1, 3'b000); expect_main("gwrap", 0, 1, 0, 1, 1);

    // Idle gaps hold everything and do not drop lock.
    step(1'b0, 1'b1, 3'b111); expect_main("idle0", 0, 1, 0, 0, 1);
    step(1'b0, 1'b0, 3'b101); expect_main("idle1", 0, 1, 0, 0, 1);
    step(1'b0, 1'b1, 3'b010); expect_main("idle2", 0, 1, 0, 0, 1);
    step(1'b1, 1'b1, 3'b001); expect_main("post_idle", 1, 1, 0, 0, 1);

    // Second break brings err_count to 2, then relock.
    step(1'b1, 1'b1, 3'b000); expect_main("brk2", 0, 0, 1, 0, 2);
    step(1'b1, 1'b1, 3'b001); expect_main("r2a", 1, 0, 0, 0, 2);
    step(1'b1, 1'b1, 3'b011); expect_main("r2b", 2, 0, 0, 0, 2);
    step(1'b1, 1'b1, 3'b010); expect_main("r2c", 3, 1, 0, 0, 2);

    // Asynchronous reset between edges clears outputs immediately.
    valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    expect_main("async_rst", 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    step(1'b1, 1'b1, 3'b110); expect_main("post_rst", 4, 0, 0, 0, 0);
    step(1'b1, 1'b1, 3'b111); expect_main("post_rst2", 5, 0, 0, 0, 0);
    valid = 1'b0;

    // Saturation on the ERR_W=2 instance: seven lock/break rounds.
    step2(1'b1, 3'd0);
    check("sat.start_locked", 32'(locked2), 0);
    for (int k = 0; k < 7; k++) begin
      step2(1'b1, 3'd1);
      step2(1'b1, 3'd2);
      step2(1'b1, 3'd3);
      check($sformatf("sat%0d.locked", k), 32'(locked2), 1);
      step2(1'b1, 3'd0);
      check($sformatf("sat%0d.seq_err", k), 32'(seq_err2), 1);
      check($sformatf("sat%0d.err_count", k), 32'(err_count2), (k + 1 > 3) ? 3 : k + 1);
    end
    step2(1'b0, 3'd0);
    check("sat.hold_err", 32'(err_count2), 3);
    check("sat.no_pulse", 32'(seq_err2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 3: consecutive correct successors required to declare lock (legal range 1..15).
REQ-002 Parameter ERR_W, default 4: width of the error counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 valid  input  1  code and mode are sampled when high.
REQ-006 mode  input  1  0 = code is 3-bit binary up-count; 1 = code is 3-bit reflected Gray (000,001,011,010,110,111,101,100, then back to 000).
REQ-007 code  input  3  count value from the upstream counter.
REQ-008 bin  output  3  binary value of the last accepted sample (registered).
REQ-009 locked  output  1  high while the sequence is in lock.
REQ-010 seq_err  output  1  one-cycle pulse; a sequence break was detected while locked.
REQ-011 wrap  output  1  one-cycle pulse; an accepted correct successor was 7 -> 0.
REQ-012 err_count  output  ERR_W  saturating count of seq_err events.

Function
REQ-013 Decode: d = code when mode=0; d = Gray-to-binary(code) when mode=1 (b2=g2, b1=g2^g1, b0=g2^g1^g0).
REQ-014 Expected value: exp = (prev_bin + 1) mod 8; the 3-bit wrap 7 -> 0 is a legal successor.
REQ-015 FSM states: HUNT (no reference held), TRACK (reference held, not locked), LOCK.
REQ-016 HUNT, valid: store d and mode; good_cnt = 0; go to TRACK; no pulses.
REQ-017 TRACK, valid, mode unchanged, d == exp: good_cnt + 1; on reaching LOCK_COUNT go to LOCK and clear good_cnt.
REQ-018 TRACK, valid, mode unchanged, d != exp: resync (store d); good_cnt = 0; stay in TRACK; no seq_err; no err_count change.
REQ-019 LOCK, valid, mode unchanged, d == exp: stay in LOCK.
REQ-020 LOCK, valid, mode unchanged, d != exp: seq_err pulse; err_count + 1 (saturates at all-ones); resync to d; good_cnt = 0; go to TRACK.
REQ-021 Mode change: a valid sample whose mode differs from the stored mode, in any state, is a resync: store d and mode; good_cnt = 0; go to TRACK; no seq_err.
REQ-022 wrap pulses when a valid sample in TRACK or LOCK equals exp and is 0 with prev_bin 7; it pulses on the locking sample too.
REQ-023 bin updates to d on every valid sample.
REQ-024 Latency: bin, locked, seq_err and wrap reflect a sample on the clock edge after the edge that sampled it (one cycle).
REQ-025 valid low: state, bin, locked and err_count hold; seq_err and wrap are 0.
REQ-026 All outputs are registered; none is combinationally derived from inputs.

Reset
REQ-027 When reset is low: state = HUNT, good_cnt = 0, stored mode = 0, bin = 0, locked = 0, seq_err = 0, wrap = 0, err_count = 0, regardless of clk.
REQ-028 Reset asserted mid-sequence discards lock and error history; the first valid sample after release is handled as in HUNT.

Structure
REQ-029 The shared package count_pkg holds the FSM state encoding, the code width constant (3) and the Gray/binary mode encodings.
REQ-030 Gray-to-binary conversion is one combinational sub-module, gray_dec3 (3-bit in, 3-bit out), instantiated once.

Verification
REQ-031 Binary lock: mode=0, valid every cycle, codes 0,1,2,3 -> locked=1 one cycle after the code 3 sample; seq_err never pulses.
REQ-032 Gray wrap: mode=1, locked, codes 110,111,101,100,000 -> bin 4,5,6,7,0; wrap pulses once, on the output cycle for 000.
REQ-033 Break in lock: mode=0, locked on 4,5,6, then code 1 -> seq_err single pulse; err_count 0 -> 1; locked=0; bin=1. Then 2,3,4 -> relock with err_count still 1.
REQ-034 Saturation: ERR_W=2, seven lock/break cycles -> err_count sticks at 3.
REQ-035 Mode change: mode=0 locked at 5, next sample mode=1 code 011 -> no seq_err; locked=0; bin=2. Then Gray 010,110,111 -> locked.
REQ-036 Async reset: reset pulsed low between clock edges while locked with err_count=2 -> all outputs 0 immediately; valid idle gaps do not affect lock.
